rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (WE3/A3/WD3) between two requesters: the pipeline writeback stage and the multi-cycle (MUL/DIV) unit.
- Pipeline writeback always has priority and is written in the same cycle.
- Multi-cycle results are queued in a small FIFO and drained into idle write-port cycles.
- A 16-bit pending scoreboard tells the hazard unit which registers still await a multi-cycle result.

---
 rtl/rf_write_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results wait in a small FIFO and drain into free cycles; PENDING tracks outstanding MC writes.
module rf_write_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PIPE_WE,
   input  logic [3:0]  PIPE_A3,
   input  logic [31:0] PIPE_WD,
   input  logic        ISSUE_VALID,
   input  logic [3:0]  ISSUE_A3,
   input  logic        MC_VALID,
   input  logic [3:0]  MC_A3,
   input  logic [31:0] MC_WD,
   output logic        MC_READY,
   output logic        WE3,
   output logic [3:0]  A3,
   output logic [31:0] WD3,
   output logic [15:0] PENDING,
   output logic        ERR
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [3:0]       ent_a3 [DEPTH];
   logic [31:0]      ent_wd [DEPTH];
   logic [DEPTH-1:0] ent_v;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;

   logic             pipe_go;
   logic             fifo_empty;
   logic             head_v;
   logic             pop;
   logic             push;
   logic             enq;
   logic             mc_r15;
   logic             mc_kill;
   logic             iss_r15;
   logic             err_set;
   logic [DEPTH-1:0] kill_mask;
   logic [15:0]      clr_mask;
   logic [15:0]      set_mask;

   // A valid head only leaves when the port is free; a killed head leaves regardless.
   always_comb begin
      pipe_go    = PIPE_WE && (PIPE_A3 != 4'hF);
      fifo_empty = (count == '0);
      head_v     = ent_v[rd_ptr];
      pop        = !fifo_empty && (!head_v || !pipe_go);
      MC_READY   = (count < CW'(DEPTH));
      push       = MC_VALID && MC_READY;
      mc_r15     = push && (MC_A3 == 4'hF);
      mc_kill    = push && pipe_go && (MC_A3 == PIPE_A3);
      enq        = push && !mc_r15 && !mc_kill;
      iss_r15    = ISSUE_VALID && (ISSUE_A3 == 4'hF);
   end

   always_comb begin
      kill_mask = '0;
      clr_mask  = '0;
      set_mask  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (pipe_go && ent_v[i] && (ent_a3[i] == PIPE_A3))
            kill_mask[i] = 1'b1;
      end
      if ((kill_mask != '0) || mc_kill)
         clr_mask[PIPE_A3] = 1'b1;
      if (pop && head_v)
         clr_mask[ent_a3[rd_ptr]] = 1'b1;
      if (ISSUE_VALID && !iss_r15)
         set_mask[ISSUE_A3] = 1'b1;
      err_set = mc_r15 || iss_r15 || (ISSUE_VALID && PENDING[ISSUE_A3]);
   end

   always_comb begin
      WE3 = 1'b0;
      A3  = '0;
      WD3 = '0;
      if (pipe_go) begin
         WE3 = 1'b1;
         A3  = PIPE_A3;
         WD3 = PIPE_WD;
      end else if (!fifo_empty && head_v) begin
         WE3 = 1'b1;
         A3  = ent_a3[rd_ptr];
         WD3 = ent_wd[rd_ptr];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         ent_v   <= '0;
         PENDING <= '0;
         ERR     <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_mask[i])
               ent_v[i] <= 1'b0;
         end
         // Pop and enqueue never target the same slot: pop needs count>0, enqueue needs count<DEPTH.
         if (pop) begin
            ent_v[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         if (enq) begin
            ent_v[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         count   <= count + CW'(enq) - CW'(pop);
         PENDING <= (PENDING & ~clr_mask) | set_mask;
         if (err_set)
            ERR <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (enq) begin
         ent_a3[wr_ptr] <= MC_A3;
         ent_wd[wr_ptr] <= MC_WD;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model.
module tb_rf_write_arbiter;

   localparam int unsigned DEPTH = 2;

   logic        CLK;
   logic        RESET;
   logic        PIPE_WE;
   logic [3:0]  PIPE_A3;
   logic [31:0] PIPE_WD;
   logic        ISSUE_VALID;
   logic [3:0]  ISSUE_A3;
   logic        MC_VALID;
   logic [3:0]  MC_A3;
   logic [31:0] MC_WD;
   logic        MC_READY;
   logic        WE3;
   logic [3:0]  A3;
   logic [31:0] WD3;
   logic [15:0] PENDING;
   logic        ERR;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [3:0]  a3;
      logic [31:0] wd;
      bit          v;
   } ent_t;

   ent_t        q[$];
   logic [15:0] m_pend = '0;
   bit          m_err  = 1'b0;

   rf_write_arbiter #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET),
      .PIPE_WE(PIPE_WE), .PIPE_A3(PIPE_A3), .PIPE_WD(PIPE_WD),
      .ISSUE_VALID(ISSUE_VALID), .ISSUE_A3(ISSUE_A3),
      .MC_VALID(MC_VALID), .MC_A3(MC_A3), .MC_WD(MC_WD),
      .MC_READY(MC_READY), .WE3(WE3), .A3(A3), .WD3(WD3),
      .PENDING(PENDING), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      RESET = 1'b0; PIPE_WE = 1'b0; PIPE_A3 = '0; PIPE_WD = '0;
      ISSUE_VALID = 1'b0; ISSUE_A3 = '0;
      MC_VALID = 1'b0; MC_A3 = '0; MC_WD = '0;
   endtask

   // Compare all outputs against the model at the falling edge.
   task automatic look();
      bit          go;
      logic        e_we;
      logic [3:0]  e_a;
      logic [31:0] e_wd;
      @(negedge CLK);
      go   = PIPE_WE && (PIPE_A3 != 4'd15);
      e_we = 1'b0; e_a = '0; e_wd = '0;
      if (go) begin
         e_we = 1'b1; e_a = PIPE_A3; e_wd = PIPE_WD;
      end else if (q.size() > 0 && q[0].v) begin
         e_we = 1'b1; e_a = q[0].a3; e_wd = q[0].wd;
      end
      chk("WE3", 32'(WE3), 32'(e_we));
      chk("A3", 32'(A3), 32'(e_a));
      chk("WD3", WD3, e_wd);
      chk("MC_READY", 32'(MC_READY), 32'(q.size() < DEPTH));
      chk("PENDING", 32'(PENDING), 32'(m_pend));
      chk("ERR", 32'(ERR), 32'(m_err));
   endtask

   // Advance the model by one clock using the inputs held across the edge.
   task automatic adv();
      bit          go;
      bit          rdy;
      logic [15:0] old;
      if (RESET) begin
         q.delete();
         m_pend = '0;
         m_err  = 1'b0;
      end else begin
         old = m_pend;
         go  = PIPE_WE && (PIPE_A3 != 4'd15);
         rdy = (q.size() < DEPTH);
         if (q.size() > 0 && (!q[0].v || !go)) begin
            if (q[0].v) m_pend[q[0].a3] = 1'b0;
            void'(q.pop_front());
         end
         if (go) begin
            foreach (q[i]) begin
               if (q[i].v && q[i].a3 == PIPE_A3) begin
                  q[i].v = 1'b0;
                  m_pend[PIPE_A3] = 1'b0;
               end
            end
         end
         if (MC_VALID && rdy) begin
            if (MC_A3 == 4'd15)
               m_err = 1'b1;
            else if (go && MC_A3 == PIPE_A3)
               m_pend[MC_A3] = 1'b0;
            else
               q.push_back('{a3: MC_A3, wd: MC_WD, v: 1'b1});
         end
         if (ISSUE_VALID) begin
            if (ISSUE_A3 == 4'd15) m_err = 1'b1;
            else begin
               if (old[ISSUE_A3]) m_err = 1'b1;
               m_pend[ISSUE_A3] = 1'b1;
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc();
      look();
      adv();
   endtask

   initial begin
      idle_in();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      // 1: idle after reset
      look();
      chk("rst_we3", 32'(WE3), 32'd0);
      chk("rst_pending", 32'(PENDING), 32'd0);
      chk("rst_ready", 32'(MC_READY), 32'd1);
      chk("rst_err", 32'(ERR), 32'd0);
      adv();

      // 2: single MC result, one-cycle latency
      ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd3; cyc();
      idle_in(); cyc(); cyc();
      MC_VALID = 1'b1; MC_A3 = 4'd3; MC_WD = 32'h0000_00AB;
      look();
      chk("t2_nobypass", 32'(WE3), 32'd0);
      adv();
      idle_in();
      look();
      chk("t2_we", 32'(WE3), 32'd1);
      chk("t2_a3", 32'(A3), 32'd3);
      chk("t2_wd", WD3, 32'hAB);
      chk("t2_pend_before", 32'(PENDING[3]), 32'd1);
      adv();
      look();
      chk("t2_once", 32'(WE3), 32'd0);
      chk("t2_pend_after", 32'(PENDING[3]), 32'd0);
      adv();

      // 3: contention, pipeline holds the port for three cycles
      ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd4; cyc();
      ISSUE_A3 = 4'd5; cyc();
      idle_in();
      PIPE_WE = 1'b1; PIPE_A3 = 4'd1; PIPE_WD = 32'hA1;
      MC_VALID = 1'b1; MC_A3 = 4'd4; MC_WD = 32'h11; cyc();
      MC_A3 = 4'd5; MC_WD = 32'h22; cyc();
      MC_VALID = 1'b0;
      look();
      chk("t3_full", 32'(MC_READY), 32'd0);
      chk("t3_pipe_a3", 32'(A3), 32'd1);
      adv();
      idle_in();
      look();
      chk("t3_d1_a3", 32'(A3), 32'd4);
      chk("t3_d1_wd", WD3, 32'h11);
      adv();
      look();
      chk("t3_d2_a3", 32'(A3), 32'd5);
      chk("t3_d2_wd", WD3, 32'h22);
      adv();
      look();
      chk("t3_done", 32'(WE3), 32'd0);
      adv();

      // 4: WAW kill of a queued R6
      ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd6; cyc();
      idle_in();
      PIPE_WE = 1'b1; PIPE_A3 = 4'd1; PIPE_WD = 32'hB1;
      MC_VALID = 1'b1; MC_A3 = 4'd6; MC_WD = 32'h55; cyc();
      MC_VALID = 1'b0; PIPE_A3 = 4'd6; PIPE_WD = 32'h99;
      look();
      chk("t4_wd", WD3, 32'h99);
      adv();
      idle_in();
      look();
      chk("t4_killed_pop", 32'(WE3), 32'd0);
      chk("t4_pend6", 32'(PENDING[6]), 32'd0);
      adv();
      cyc();

      // 5: protocol errors
      MC_VALID = 1'b1; MC_A3 = 4'd15; MC_WD = 32'hDEAD;
      look();
      chk("t5_err_pre", 32'(ERR), 32'd0);
      adv();
      idle_in();
      ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd2; cyc();
      cyc();
      idle_in();
      look();
      chk("t5_err", 32'(ERR), 32'd1);
      chk("t5_no_r15", 32'(WE3), 32'd0);
      adv();
      repeat (3) cyc();
      look();
      chk("t5_sticky", 32'(ERR), 32'd1);
      adv();

      // 6: reset mid-drain
      RESET = 1'b1; cyc();
      idle_in();
      ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd4; cyc();
      ISSUE_A3 = 4'd5; cyc();
      idle_in();
      PIPE_WE = 1'b1; PIPE_A3 = 4'd1; PIPE_WD = 32'hC1;
      MC_VALID = 1'b1; MC_A3 = 4'd4; MC_WD = 32'h44; cyc();
      MC_A3 = 4'd5; MC_WD = 32'h45; cyc();
      MC_VALID = 1'b0;
      RESET = 1'b1;
      look();
      chk("t6_pend", 32'(PENDING), 32'h30);
      adv();
      idle_in();
      for (int k = 0; k < 3; k++) begin
         look();
         chk("t6_we3", 32'(WE3), 32'd0);
         chk("t6_pend0", 32'(PENDING), 32'd0);
         adv();
      end

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         RESET       = ($urandom_range(0, 59) == 0);
         PIPE_WE     = ($urandom_range(0, 1) == 1);
         PIPE_A3     = 4'($urandom_range(0, 15));
         PIPE_WD     = $urandom;
         ISSUE_VALID = ($urandom_range(0, 3) == 0);
         ISSUE_A3    = 4'($urandom_range(0, 15));
         MC_VALID    = ($urandom_range(0, 4) < 2);
         MC_A3       = 4'($urandom_range(0, 15));
         MC_WD       = $urandom;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
